// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: drain FSM states and
// the write-buffer entry layout {word index, store data}.
package dmem_pkg;

   localparam int N_W     = 64;
   localparam int DEPTH_W = 64;
   localparam int IDX_W   = $clog2(DEPTH_W);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [N_W-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer with sticky overflow flag and a newest-first
// associative lookup used for store-to-load forwarding.
module wbuf_fifo
   import dmem_pkg::*;
#(
   parameter int WB_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  wb_entry_t        i_push_entry,
   input  logic             i_pop,
   input  logic [IDX_W-1:0] i_lookup_idx,
   output wb_entry_t        o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow,
   output logic             o_hit,
   output logic [N_W-1:0]   o_hit_data
);

   localparam int PTR_W = $clog2(WB_DEPTH);

   wb_entry_t        r_mem [WB_DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             r_overflow;
   logic             w_accept;
   logic             w_drop;
   logic [PTR_W-1:0] w_pos;
   logic             w_hit;
   logic [N_W-1:0]   w_hit_data;

   // A full buffer still accepts a store when the head leaves on the same edge.
   assign w_accept   = i_push & (~o_full | i_pop);
   assign w_drop     = i_push & o_full & ~i_pop;
   assign o_full     = (r_count == (PTR_W+1)'(WB_DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_head     = r_mem[r_head];
   assign o_overflow = r_overflow;
   assign o_hit      = w_hit;
   assign o_hit_data = w_hit_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) r_tail <= r_tail + PTR_W'(1);
         if (i_pop)    r_head <= r_head + PTR_W'(1);
         if (w_drop)   r_overflow <= 1'b1;
         case ({w_accept, i_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_tail] <= i_push_entry;
   end

   // Walk oldest to newest so the last match (the newest store) wins.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      w_pos      = '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
         w_pos = r_head + PTR_W'(k);
         if (((PTR_W+1)'(k) < r_count) && (r_mem[w_pos].idx == i_lookup_idx)) begin
            w_hit      = 1'b1;
            w_hit_data = r_mem[w_pos].data;
         end
      end
   end

endmodule

// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: same-cycle loads with forwarding, posted stores
// drained into a slow-write word array by a two-state FSM.
module dmem_wbuf_responder
   import dmem_pkg::*;
#(
   parameter int N         = N_W,
   parameter int DEPTH     = DEPTH_W,
   parameter int WB_DEPTH  = 4,
   parameter int WRITE_LAT = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         DM_readEnable,
   input  logic         DM_writeEnable,
   input  logic [N-1:0] DM_addr,
   input  logic [N-1:0] DM_writeData,
   output logic [N-1:0] DM_readData,
   output logic         wb_full,
   output logic         wb_empty,
   output logic         wb_overflow
);

   localparam int CNT_W = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;

   logic [N-1:0]       r_mem [DEPTH];
   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_pop;
   logic [IDX_W-1:0]   w_idx;
   logic [N-IDX_W-1:0] w_unused_addr;
   wb_entry_t          w_push_entry;
   wb_entry_t          w_head;
   logic               w_hit;
   logic [N-1:0]       w_hit_data;

   assign w_idx         = DM_addr[IDX_W+2:3];
   assign w_unused_addr = {DM_addr[N-1:IDX_W+3], DM_addr[2:0]};
   assign w_push_entry  = '{idx: w_idx, data: DM_writeData};

   wbuf_fifo #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
      .clk          (clk),
      .reset        (reset),
      .i_push       (DM_writeEnable),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_lookup_idx (w_idx),
      .o_head       (w_head),
      .o_full       (wb_full),
      .o_empty      (wb_empty),
      .o_overflow   (wb_overflow),
      .o_hit        (w_hit),
      .o_hit_data   (w_hit_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == IDLE) && !wb_empty)
            r_cnt <= CNT_W'(WRITE_LAT - 1);
         else if ((r_state == BUSY) && (r_cnt != '0))
            r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = wb_empty ? IDLE : BUSY;
         BUSY:    w_next_state = (r_cnt == '0) ? IDLE : BUSY;
         default: w_next_state = IDLE;
      endcase
   end

   // The head entry is committed and popped on the same edge.
   always_comb begin
      w_pop = (r_state == BUSY) && (r_cnt == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_pop) begin
         r_mem[w_head.idx] <= w_head.data;
      end
   end

   assign DM_readData = !DM_readEnable ? '0 :
                        w_hit          ? w_hit_data : r_mem[w_idx];

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Scoreboard bench for dmem_wbuf_responder: load expectations are queued
// when a load is driven and compared when the cycle's output is sampled.
module tb_dmem_wbuf_responder;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        DM_readEnable = 1'b0;
   logic        DM_writeEnable = 1'b0;
   logic [63:0] DM_addr = 64'h0;
   logic [63:0] DM_writeData = 64'h0;
   logic [63:0] DM_readData;
   logic        wb_full, wb_empty, wb_overflow;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q [$];
   logic [63:0] e;

   dmem_wbuf_responder dut (
      .clk(clk), .reset(reset),
      .DM_readEnable(DM_readEnable), .DM_writeEnable(DM_writeEnable),
      .DM_addr(DM_addr), .DM_writeData(DM_writeData), .DM_readData(DM_readData),
      .wb_full(wb_full), .wb_empty(wb_empty), .wb_overflow(wb_overflow)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic re, input logic we, input logic [63:0] a, input logic [63:0] d);
      DM_readEnable = re; DM_writeEnable = we; DM_addr = a; DM_writeData = d;
   endtask

   task automatic ld(input logic [63:0] a, input logic [63:0] ex);
      drive(1'b1, 1'b0, a, 64'h0);
      exp_q.push_back(ex);
   endtask

   task automatic st(input logic [63:0] a, input logic [63:0] d);
      drive(1'b0, 1'b1, a, d);
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   task automatic wait_drain;
      int n;
      drive(1'b0, 1'b0, 64'h0, 64'h0);
      n = 0;
      while (!(wb_empty && dut.r_state == IDLE) && n < 100) begin nxt(); n++; end
      checks++;
      if (n >= 100) begin failures++; $display("FAIL drain_timeout got=%0d cycles exp<100", n); end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(1'b0, 1'b0, 64'h0, 64'h0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      ld(64'h40, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rst_load got=%h exp=%h", DM_readData, e); end
      checks++; if (wb_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", wb_empty); end
      checks++; if (wb_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", wb_full); end
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", wb_overflow); end
      nxt();
   endtask

   task automatic test_forward;
      st(64'h08, 64'hDEAD);                       // cycle 0, pushed at edge 0
      nxt(); ld(64'h08, 64'hDEAD);                // cycle 1
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL fwd_c1 got=%h exp=%h", DM_readData, e); end
      checks++; if (wb_empty !== 1'b0) begin failures++; $display("FAIL fwd_nonempty got=%b exp=0", wb_empty); end
      nxt(); drive(1'b0, 1'b0, 64'h0, 64'h0);    // cycle 2
      nxt();                                      // cycle 3
      nxt(); ld(64'h08, 64'hDEAD);                // cycle 4, entry still queued
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL fwd_c4 got=%h exp=%h", DM_readData, e); end
      checks++; if (dut.r_mem[1] !== 64'h0) begin failures++; $display("FAIL fwd_precommit got=%h exp=0", dut.r_mem[1]); end
      nxt(); drive(1'b0, 1'b0, 64'h0, 64'h0);    // cycle 5, after edge 4
      @(negedge clk);
      checks++; if (dut.r_mem[1] !== 64'hDEAD) begin failures++; $display("FAIL fwd_commit got=%h exp=dead", dut.r_mem[1]); end
      nxt(); ld(64'h08, 64'hDEAD);                // cycle 6
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL fwd_c6 got=%h exp=%h", DM_readData, e); end
      checks++; if (wb_empty !== 1'b1) begin failures++; $display("FAIL fwd_empty got=%b exp=1", wb_empty); end
      nxt();
   endtask

   task automatic test_rw_same_cycle;
      drive(1'b1, 1'b1, 64'h0F, 64'hBEEF);        // low bits ignored: word 1
      exp_q.push_back(64'hDEAD);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rw_pre got=%h exp=%h", DM_readData, e); end
      nxt(); ld(64'h08, 64'hBEEF);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rw_post got=%h exp=%h", DM_readData, e); end
      nxt(); drive(1'b0, 1'b0, 64'h0, 64'h0);
      @(negedge clk);
      checks++; if (DM_readData !== 64'h0) begin failures++; $display("FAIL noread_zero got=%h exp=0", DM_readData); end
      wait_drain();
   endtask

   task automatic test_duplicate;
      st(64'h10, 64'h1111);
      nxt(); st(64'h10, 64'h2222);
      nxt(); ld(64'h10, 64'h2222);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL dup_fwd got=%h exp=%h", DM_readData, e); end
      nxt(); wait_drain();
      checks++; if (dut.r_mem[2] !== 64'h2222) begin failures++; $display("FAIL dup_array got=%h exp=2222", dut.r_mem[2]); end
      ld(64'h10, 64'h2222);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL dup_load got=%h exp=%h", DM_readData, e); end
      nxt();
   endtask

   task automatic test_full_and_overflow;
      for (int i = 0; i < 4; i++) begin
         st(64'h20 + 64'(8*i), 64'hA0 + 64'(i));
         nxt();
      end
      st(64'h40, 64'hA4);                         // lands on the first pop edge
      @(negedge clk);
      checks++; if (wb_full !== 1'b1) begin failures++; $display("FAIL full_after4 got=%b exp=1", wb_full); end
      checks++; if (!(dut.r_state == BUSY && dut.r_cnt == '0)) begin failures++; $display("FAIL pop_cycle got=%0d exp=BUSY/0", dut.r_cnt); end
      nxt(); st(64'h48, 64'hA5);                  // full, FSM idle: dropped
      @(negedge clk);
      checks++; if (wb_full !== 1'b1) begin failures++; $display("FAIL full_after_pop got=%b exp=1", wb_full); end
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL ovf_on_pop got=%b exp=0", wb_overflow); end
      checks++; if (dut.r_mem[4] !== 64'hA0) begin failures++; $display("FAIL first_commit got=%h exp=a0", dut.r_mem[4]); end
      nxt(); ld(64'h48, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL dropped_fwd got=%h exp=%h", DM_readData, e); end
      checks++; if (wb_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", wb_overflow); end
      nxt(); wait_drain();
      checks++; if (wb_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", wb_overflow); end
      checks++; if (dut.r_mem[7] !== 64'hA3) begin failures++; $display("FAIL last_fill got=%h exp=a3", dut.r_mem[7]); end
      ld(64'h48, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL dropped_old got=%h exp=%h", DM_readData, e); end
      nxt(); ld(64'h40, 64'hA4);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL pop_push_data got=%h exp=%h", DM_readData, e); end
      nxt();
   endtask

   task automatic test_reset_mid_drain;
      st(64'h50, 64'hC0);
      nxt(); st(64'h58, 64'hC1);
      nxt(); st(64'h60, 64'hC2);
      nxt(); drive(1'b0, 1'b0, 64'h0, 64'h0);
      #2 reset = 1'b1;
      #1;
      checks++; if (wb_empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%b exp=1", wb_empty); end
      checks++; if (dut.r_state != IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", dut.r_state); end
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf got=%b exp=0", wb_overflow); end
      @(posedge clk); #1 reset = 1'b0;
      ld(64'h50, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rst_q0 got=%h exp=%h", DM_readData, e); end
      nxt(); ld(64'h60, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rst_q2 got=%h exp=%h", DM_readData, e); end
      nxt(); ld(64'h08, 64'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (DM_readData !== e) begin failures++; $display("FAIL rst_array_clr got=%h exp=%h", DM_readData, e); end
      nxt(); drive(1'b0, 1'b0, 64'h0, 64'h0);
   endtask

   initial begin
      test_reset();
      test_forward();
      test_rw_same_cycle();
      test_duplicate();
      test_full_and_overflow();
      test_reset_mid_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
